// File: rtl/maxpool_sched.sv
// rtl/maxpool_sched.sv - 2x2/stride-2 max-pool scheduler with half-width line buffer
module maxpool_sched #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_POOL     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         in_sof,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         sync_err
);

    localparam int CW = (IMAGE_WIDTH  > 2) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int LD = IMAGE_WIDTH / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    typedef enum logic {S_EVEN = 1'b0, S_ODD = 1'b1} state_t;

    state_t                        r_state, w_state_cur, w_state_nxt;
    logic [CW-1:0]                 r_col, w_col_cur, w_col_nxt;
    logic [RW-1:0]                 r_row, w_row_cur, w_row_nxt;
    logic signed [DATA_WIDTH-1:0]  r_hold;
    logic signed [DATA_WIDTH-1:0]  r_lbuf [LD];
    logic signed [DATA_WIDTH-1:0]  w_h, w_pool;
    logic [LW-1:0]                 w_lidx;
    logic                          w_sof, w_col_wrap, w_row_wrap, w_at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EVEN;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // A qualified in_sof relabels the current pixel as (0,0) before anything else looks at position.
    always_comb begin
        w_sof       = in_valid & in_sof;
        w_col_cur   = w_sof ? '0 : r_col;
        w_row_cur   = w_sof ? '0 : r_row;
        w_state_cur = w_sof ? S_EVEN : r_state;
        w_col_wrap  = (w_col_cur == CW'(IMAGE_WIDTH - 1));
        w_row_wrap  = (w_row_cur == RW'(IMAGE_HEIGHT - 1));
        w_at_end    = w_col_wrap & w_row_wrap;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_state_nxt = r_state;
        if (in_valid) begin
            w_col_nxt   = w_col_wrap ? '0 : w_col_cur + CW'(1);
            w_row_nxt   = w_row_cur;
            w_state_nxt = w_state_cur;
            if (w_col_wrap) begin
                w_row_nxt   = w_row_wrap ? '0 : w_row_cur + RW'(1);
                w_state_nxt = (w_state_cur == S_EVEN) ? S_ODD : S_EVEN;
            end
        end
        w_lidx = LW'(w_col_cur >> 1);
        w_h    = (r_hold > in_data) ? r_hold : in_data;
        w_pool = (r_lbuf[w_lidx] > w_h) ? r_lbuf[w_lidx] : w_h;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sync_err  <= 1'b0;
            r_hold    <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (w_sof && (r_col != '0 || r_row != '0))
                sync_err <= 1'b1;
            if (in_valid) begin
                if (MAX_POOL == 0) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                    out_last  <= w_at_end;
                end else if (!w_col_cur[0]) begin
                    r_hold <= in_data;
                end else if (w_state_cur == S_ODD) begin
                    out_data  <= w_pool;
                    out_valid <= 1'b1;
                    out_last  <= w_at_end;
                end
            end
        end
    end

    // Even rows park the horizontal pair max; odd rows consume it on the same column pair.
    always_ff @(posedge clk) begin
        if (MAX_POOL != 0 && in_valid && w_col_cur[0] && w_state_cur == S_EVEN)
            r_lbuf[w_lidx] <= w_h;
    end

endmodule
